// File: rtl/sle_bank_if.sv
// sle_bank_if: control/data bundle between a bank controller and its driver.
// Optional feature macro: SLE_BANK_PARITY_EN adds the parity_err status line.
interface sle_bank_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             mode;
    logic             sdi;
    logic             sdi_valid;
    logic             abort;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             EN_o;
    logic             SLn_o;
    logic             busy;
    logic             done;
`ifdef SLE_BANK_PARITY_EN
    logic             parity_err;
`endif

    // Driver side: issues requests and data, observes bank status.
    modport master (
        output start, mode, sdi, sdi_valid, abort, D,
`ifdef SLE_BANK_PARITY_EN
        input  parity_err,
`endif
        input  Q, EN_o, SLn_o, busy, done
    );

    // Controller side.
    modport slave (
        input  start, mode, sdi, sdi_valid, abort, D,
`ifdef SLE_BANK_PARITY_EN
        output parity_err,
`endif
        output Q, EN_o, SLn_o, busy, done
    );
endinterface

// File: rtl/sle_bank_ctrl.sv
// sle_bank_ctrl: storage bank loaded either serially (MSB first, qualified
// by sdi_valid, abortable) or by one-cycle parallel capture of D.
// Optional feature macro: SLE_BANK_PARITY_EN -- serial load takes one extra
// even-parity bit, checked at completion and reported on parity_err.
module sle_bank_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic        CLk,
    input  logic        ALn,
    sle_bank_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
`ifdef SLE_BANK_PARITY_EN
    localparam int unsigned N_BITS = WIDTH + 1;
`else
    localparam int unsigned N_BITS = WIDTH;
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] q_q;
    logic             accept_c;
    logic             last_c;
    logic             store_c;
    logic             launch_c;

    // A serial bit is taken only when valid and not overridden by abort.
    assign accept_c = (state_q == ST_SHIFT) && bus.sdi_valid && !bus.abort;
    assign last_c   = accept_c && (cnt_q == CNT_W'(N_BITS - 1));
    assign launch_c = (state_q == ST_IDLE) && bus.start && !bus.abort;
`ifdef SLE_BANK_PARITY_EN
    // The trailing parity bit is consumed but never stored in Q.
    assign store_c  = accept_c && (cnt_q < CNT_W'(WIDTH));
`else
    assign store_c  = accept_c;
`endif

    // State register.
    always_ff @(posedge CLk or negedge ALn) begin
        if (!ALn) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic; abort in SHIFT wins over a same-cycle bit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (launch_c) state_d = bus.mode ? ST_CAPTURE : ST_SHIFT;
            end
            ST_SHIFT: begin
                if (bus.abort)   state_d = ST_IDLE;
                else if (last_c) state_d = ST_DONE;
            end
            ST_CAPTURE: state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Bit counter: cleared when a load launches, advanced per accepted bit.
    always_ff @(posedge CLk or negedge ALn) begin
        if (!ALn)                               cnt_q <= '0;
        else if (launch_c && !bus.mode)         cnt_q <= '0;
        else if (accept_c)                      cnt_q <= cnt_q + CNT_W'(1);
    end

    // Bank contents: serial shift or parallel capture.
    always_ff @(posedge CLk or negedge ALn) begin
        if (!ALn)                         q_q <= '0;
        else if (store_c)                 q_q <= {q_q[WIDTH-2:0], bus.sdi};
        else if (state_q == ST_CAPTURE)   q_q <= bus.D;
    end

`ifdef SLE_BANK_PARITY_EN
    logic par_acc_q;
    logic parity_err_q;

    // Running XOR of accepted data bits; result latched with the parity bit.
    always_ff @(posedge CLk or negedge ALn) begin
        if (!ALn) begin
            par_acc_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else if (launch_c) begin
            par_acc_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else if (last_c) begin
            parity_err_q <= par_acc_q ^ bus.sdi;
        end else if (store_c) begin
            par_acc_q    <= par_acc_q ^ bus.sdi;
        end
    end

    assign bus.parity_err = parity_err_q;
`endif

    // Status decoded from the state register; EN_o follows the update enable.
    assign bus.Q     = q_q;
    assign bus.EN_o  = store_c || (state_q == ST_CAPTURE);
    assign bus.SLn_o = (state_q != ST_SHIFT);
    assign bus.busy  = (state_q != ST_IDLE);
    assign bus.done  = (state_q == ST_DONE);
endmodule

// File: doc/sle_bank_ctrl.md
SLE_BANK_CTRL -- requirements
Module: sle_bank_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the number of storage bits in the bank (legal range 2..32).
REQ-002 Port CLk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port ALn, input, 1 bit, SHALL be the reset, asynchronous and active-low.
REQ-004 Port start, input, 1 bit, SHALL request an operation; it is sampled only in IDLE.
REQ-005 Port mode, input, 1 bit, SHALL select the operation at start: 0 = serial load, 1 = parallel capture.
REQ-006 Port sdi, input, 1 bit, SHALL carry serial load data, MSB first.
REQ-007 Port sdi_valid, input, 1 bit, SHALL qualify sdi; a shift occurs only when it is high.
REQ-008 Port abort, input, 1 bit, SHALL cancel a serial load in progress.
REQ-009 Port D, input, WIDTH bits, SHALL be the parallel capture data.
REQ-010 Port Q, output, WIDTH bits, SHALL be the registered bank contents.
REQ-011 Port EN_o, output, 1 bit, SHALL be high in exactly the cycles whose closing edge updates Q.
REQ-012 Port SLn_o, output, 1 bit, SHALL be 0 while in SHIFT (serial path selected) and 1 otherwise.
REQ-013 Port busy, output, 1 bit, SHALL be high in every state except IDLE.
REQ-014 Port done, output, 1 bit, SHALL be a one-cycle pulse marking successful completion.

Function
REQ-015 The FSM SHALL have the states IDLE, SHIFT, CAPTURE and DONE, state-encoded and registered.
- IDLE, start=1, abort=0, mode=0 -> SHIFT.
- IDLE, start=1, abort=0, mode=1 -> CAPTURE.
REQ-016 In SHIFT, each cycle with sdi_valid=1 SHALL perform Q <= {Q[WIDTH-2:0], sdi} and increment the bit counter; cycles with sdi_valid=0 SHALL hold Q and the counter (stall).
REQ-017 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL clear on entry to SHIFT.
REQ-018 After the WIDTH-th accepted bit, SHIFT SHALL transition to DONE; a serial load therefore takes WIDTH valid cycles plus stall cycles.
REQ-019 CAPTURE SHALL load Q <= D in one cycle and then transition to DONE.
REQ-020 DONE SHALL assert done=1 for exactly one cycle and then return to IDLE.
REQ-021 start SHALL be ignored while busy=1; no queuing.
REQ-022 abort=1 in SHIFT SHALL transition to IDLE on the next edge.
- Q retains the partially shifted value.
- done is not asserted.
- An sdi_valid bit on the same edge is NOT shifted (abort has priority).
REQ-023 abort in CAPTURE or DONE SHALL have no effect; abort together with start in IDLE SHALL keep the FSM in IDLE.
REQ-024 EN_o SHALL equal (SHIFT and sdi_valid and not abort) or CAPTURE, combinationally.

Reset
REQ-025 On ALn=0, the block SHALL, asynchronously and regardless of CLk:
- enter IDLE;
- clear the counter;
- set Q=0, done=0, busy=0, EN_o=0, SLn_o=1.
REQ-026 Reset asserted mid-SHIFT or mid-CAPTURE SHALL discard the operation without a done pulse; operation resumes on the first rising CLk after ALn returns high.

Configuration
REQ-027 With macro SLE_BANK_PARITY_EN defined, the block SHALL add a 1-bit output parity_err.
- parity_err is registered.
- Serial load accepts WIDTH+1 bits; the last bit is an even-parity bit not stored in Q.
- At DONE, parity_err=1 if the XOR of the WIDTH data bits and the parity bit is 1.
- parity_err holds until the next start and is cleared by reset.
REQ-028 Without SLE_BANK_PARITY_EN, port parity_err SHALL NOT exist and serial load SHALL take exactly WIDTH bits.

Verification (WIDTH=8)
REQ-029 Reset: hold ALn=0 with random inputs -> Q=0x00, busy=0, done=0, SLn_o=1.
REQ-030 Serial load: start, mode=0, sdi bits 1,0,1,1,0,0,1,0 each with sdi_valid=1 -> Q=0xB2 and done pulses on the following cycle.
- During the load, busy=1 and SLn_o=0.
REQ-031 Stall: same sequence with sdi_valid=0 inserted for 3 cycles after bit 4 -> Q=0xB2, done 3 cycles later than REQ-030, Q unchanged during the stalls.
REQ-032 Capture: start, mode=1, D=0x5A -> Q=0x5A after 1 cycle, done next cycle, EN_o high for exactly 1 cycle.
REQ-033 Abort: after 5 bits 1,1,0,1,0 from Q=0x00, assert abort with sdi_valid=1 -> FSM in IDLE, Q=0x1A, no done pulse.
- A start issued during busy is ignored.
REQ-034 Parity (macro defined): load 0xB2 followed by parity bit 0 -> parity_err=0; parity bit 1 -> parity_err=1.
